// File: rtl/alu_sequencer_pkg.sv
// Shared types and widths for the ALU front-end sequencer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package alu_seq_pkg;

    localparam int OPCODE_W         = 6;
    localparam int OPERAND_W        = 10;
    localparam int PRESS_CNT_W      = 8;
    localparam int DEBOUNCE_DEFAULT = 20000;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_WAIT_STABLE  = 2'd1,
        ST_WAIT_RELEASE = 2'd2
    } state_e;

    // Bits needed to hold a stability count of 0 .. cycles-1.
    function automatic int cnt_w(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

    localparam int CNT_W = cnt_w(DEBOUNCE_DEFAULT);

endpackage

// File: rtl/alu_sequencer_if.sv
// Switch inputs and registered ALU-facing outputs of the sequencer.
// Latency: none (wiring only).
// Backpressure: none; switches are sampled every cycle, outputs are levels.
interface alu_sequencer_if;
    import alu_seq_pkg::*;

    logic [OPCODE_W-1:0]    push_sw;
    logic [OPERAND_W-1:0]   dip_sw;
    logic [OPERAND_W-1:0]   alu_operand;
    logic [OPCODE_W-1:0]    alu_opcode;
    logic                   valid;
    logic                   err;
    logic [PRESS_CNT_W-1:0] press_cnt;

    // Board side: drives the switches, observes the ALU controls.
    modport master (
        output push_sw, dip_sw,
        input  alu_operand, alu_opcode, valid, err, press_cnt
    );

    // Sequencer side.
    modport slave (
        input  push_sw, dip_sw,
        output alu_operand, alu_opcode, valid, err, press_cnt
    );

endinterface

// File: rtl/alu_sequencer_sync2ff.sv
// Two-flop synchronizer for asynchronous switch inputs, cleared to zero on reset.
// Latency: 2 cycles from input to output.
// Backpressure: none.
module sync2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two-stage capture; first stage may go metastable, second settles it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/alu_sequencer.sv
// Debounces push switches and latches one-hot opcode plus DIP operand per accepted press.
// Latency: outputs update DEBOUNCE_CYCLES+2 edges after the first edge sampling a held press.
// Backpressure: none; a press held past acceptance is ignored until a debounced release.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_sequencer_if.slave     bus
);

    localparam int            CW      = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [OPCODE_W-1:0]    btn_sync;
    logic [OPERAND_W-1:0]   dip_sync;
    logic [OPCODE_W-1:0]    btn_prev_q;
    logic [OPERAND_W-1:0]   dip_prev_q;
    logic [CW-1:0]          stab_cnt_q, stab_cnt_d;
    state_e                 state_q, state_d;
    logic [OPCODE_W-1:0]    opcode_q, opcode_d;
    logic [OPERAND_W-1:0]   operand_q, operand_d;
    logic                   valid_q, valid_d;
    logic                   err_q, err_d;
    logic [PRESS_CNT_W-1:0] press_cnt_q, press_cnt_d;
    logic                   changed;
    logic                   stable;
    logic                   btn_zero;

    sync2ff #(.WIDTH(OPCODE_W)) u_sync_btn (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (bus.push_sw),
        .q_o   (btn_sync)
    );

    sync2ff #(.WIDTH(OPERAND_W)) u_sync_dip (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (bus.dip_sw),
        .q_o   (dip_sync)
    );

    // The counter value lags a change by one edge, so "stable" also requires
    // no change this cycle; otherwise a stale saturated count would be trusted.
    assign changed  = ({btn_sync, dip_sync} != {btn_prev_q, dip_prev_q});
    assign stable   = !changed && (stab_cnt_q == CNT_MAX);
    assign btn_zero = (btn_sync == '0);

    // Stability counter: restart on any input change, saturate at the threshold.
    always_comb begin
        stab_cnt_d = stab_cnt_q;
        if (changed) begin
            stab_cnt_d = '0;
        end else if (stab_cnt_q != CNT_MAX) begin
            stab_cnt_d = stab_cnt_q + 1'b1;
        end
    end

    // Delayed copy of the synchronized inputs and the stability count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_prev_q <= '0;
            dip_prev_q <= '0;
            stab_cnt_q <= '0;
        end else begin
            btn_prev_q <= btn_sync;
            dip_prev_q <= dip_sync;
            stab_cnt_q <= stab_cnt_d;
        end
    end

    // Press FSM: next state and output-register updates at the decision edge.
    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        operand_d   = operand_q;
        valid_d     = valid_q;
        err_d       = err_q;
        press_cnt_d = press_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (!btn_zero) begin
                    state_d = ST_WAIT_STABLE;
                end
            end
            ST_WAIT_STABLE: begin
                if (btn_zero) begin
                    state_d = ST_IDLE;
                end else if (stable) begin
                    if ($onehot(btn_sync)) begin
                        opcode_d    = btn_sync;
                        operand_d   = dip_sync;
                        valid_d     = 1'b1;
                        err_d       = 1'b0;
                        press_cnt_d = press_cnt_q + 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = ST_WAIT_RELEASE;
                end
            end
            ST_WAIT_RELEASE: begin
                if (btn_zero && stable) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state and ALU-facing output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            opcode_q    <= '0;
            operand_q   <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            press_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            opcode_q    <= opcode_d;
            operand_q   <= operand_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            press_cnt_q <= press_cnt_d;
        end
    end

    assign bus.alu_opcode  = opcode_q;
    assign bus.alu_operand = operand_q;
    assign bus.valid       = valid_q;
    assign bus.err         = err_q;
    assign bus.press_cnt   = press_cnt_q;

endmodule
